// File: rtl/wavelet_sched_if.sv
// Bundle of the wavelet_sched handshakes: sample input, coefficient-table
// lookup, and the serialized filter-result output plus the busy flag.
// The sequencer attaches through the master modport, its environment through slave.
interface wavelet_sched_if #(
    parameter int BITS_PER_ELEM = 8,
    parameter int NUM_ELEM      = 7,
    parameter int NUM_FILTERS   = 4
);
    localparam int ACC_W = 2*BITS_PER_ELEM + $clog2(NUM_ELEM);
    localparam int FW    = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
    localparam int KW    = $clog2(NUM_ELEM);

    logic [BITS_PER_ELEM-1:0] sample_in;
    logic                     sample_valid;
    logic                     sample_ready;
    logic [FW-1:0]            coef_filt;
    logic [KW-1:0]            coef_idx;
    logic [BITS_PER_ELEM-1:0] coef_data;
    logic [ACC_W-1:0]         out_data;
    logic [FW-1:0]            out_filt;
    logic                     out_valid;
    logic                     out_ready;
    logic                     busy;

    modport master (
        input  sample_in, sample_valid, coef_data, out_ready,
        output sample_ready, coef_filt, coef_idx, out_data, out_filt, out_valid, busy
    );

    modport slave (
        output sample_in, sample_valid, coef_data, out_ready,
        input  sample_ready, coef_filt, coef_idx, out_data, out_filt, out_valid, busy
    );
endinterface

// File: rtl/wavelet_sched.sv
// Wavelet filter-bank sequencer: keeps a NUM_ELEM-tap sample window and runs
// one shared MAC over NUM_FILTERS coefficient sets per accepted sample,
// emitting each filter sum with its filter id under valid/ready.
// Optional build macro WAVELET_SCHED_DECIM_EN: decimate by 2 (sweep only on
// every second accepted sample).
module wavelet_sched #(
    parameter int BITS_PER_ELEM = 8,
    parameter int NUM_ELEM      = 7,
    parameter int NUM_FILTERS   = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    wavelet_sched_if.master bus
);
    localparam int ACC_W = 2*BITS_PER_ELEM + $clog2(NUM_ELEM);
    localparam int FW    = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
    localparam int KW    = $clog2(NUM_ELEM);
    localparam int PW    = 2*BITS_PER_ELEM;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                   state;
    logic [BITS_PER_ELEM-1:0] win [NUM_ELEM];
    logic [ACC_W-1:0]         acc;
    logic [FW-1:0]            f;
    logic [FW-1:0]            cf;
    logic [KW-1:0]            k;
    logic                     ov;
    logic [PW-1:0]            prod;
    logic                     start;
`ifdef WAVELET_SCHED_DECIM_EN
    logic                     phase;
`endif

    // Full-width unsigned product of the addressed coefficient and tap.
    assign prod = {{BITS_PER_ELEM{1'b0}}, bus.coef_data} * {{BITS_PER_ELEM{1'b0}}, win[k]};

    // An accepted sample starts a sweep unless decimation skips this phase.
`ifdef WAVELET_SCHED_DECIM_EN
    assign start = phase;
`else
    assign start = 1'b1;
`endif

    // Sequencer FSM: window shift, MAC accumulation, and result hand-off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            for (int i = 0; i < NUM_ELEM; i++) win[i] <= '0;
            acc   <= '0;
            f     <= '0;
            cf    <= '0;
            k     <= '0;
            ov    <= 1'b0;
`ifdef WAVELET_SCHED_DECIM_EN
            phase <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.sample_valid) begin
                        win[0] <= bus.sample_in;
                        for (int i = 1; i < NUM_ELEM; i++) win[i] <= win[i-1];
`ifdef WAVELET_SCHED_DECIM_EN
                        phase <= ~phase;
`endif
                        if (start) begin
                            f     <= '0;
                            cf    <= '0;
                            k     <= '0;
                            state <= MAC;
                        end
                    end
                end
                MAC: begin
                    if (k == '0) acc <= {{(ACC_W-PW){1'b0}}, prod};
                    else         acc <= acc + {{(ACC_W-PW){1'b0}}, prod};
                    if (k == KW'(NUM_ELEM-1)) begin
                        state <= OUT;
                        ov    <= 1'b1;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        ov <= 1'b0;
                        if (f == FW'(NUM_FILTERS-1)) begin
                            f     <= '0;
                            state <= IDLE;
                        end else begin
                            f     <= f + 1'b1;
                            cf    <= f + 1'b1;
                            k     <= '0;
                            state <= MAC;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The coefficient index tracks k directly; k only moves while a sweep runs.
    assign bus.coef_filt    = cf;
    assign bus.coef_idx     = k;
    assign bus.out_data     = acc;
    assign bus.out_filt     = f;
    assign bus.out_valid    = ov;
    assign bus.sample_ready = (state == IDLE);
    assign bus.busy         = (state != IDLE);

endmodule

// File: doc/wavelet_sched.md
Name: wavelet_sched

Overview:
Sequencer for the wavelet filter bank. It holds one NUM_ELEM-sample tap window, accepts one input sample at a time, and time-multiplexes a single MAC across NUM_FILTERS coefficient sets (one set per centre frequency). Each result is serialized out with filter id under valid/ready. Coefficients come from an external per-filter coefficient table, addressed by this block and read combinationally in the same cycle.

Parameters:
BITS_PER_ELEM, 8, width of one sample and one coefficient (unsigned)
NUM_ELEM, 7, taps per filter (>=2)
NUM_FILTERS, 4, coefficient sets / centre frequencies (>=1)
Derived: ACC_W = 2*BITS_PER_ELEM + $clog2(NUM_ELEM); FW = max(1,$clog2(NUM_FILTERS)); KW = $clog2(NUM_ELEM)

Ports:
clk  in  1  clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
sample_in  in  BITS_PER_ELEM  new sample
sample_valid  in  1  sample_in valid
sample_ready  out  1  high only in IDLE
coef_filt  out  FW  coefficient-table filter select
coef_idx  out  KW  coefficient-table tap select
coef_data  in  BITS_PER_ELEM  coefficient at (coef_filt, coef_idx), same cycle
out_data  out  ACC_W  filter sum
out_filt  out  FW  filter id of out_data
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync deassert by clock use): state=IDLE; window all zero; acc/out_data=0; f=0; k=0; out_valid=0; out_filt=0; coef_filt=0; coef_idx=0; busy=0; sample_ready=1 after reset release. Reset mid-operation aborts the sweep and discards the in-flight result.
- States: IDLE, MAC, OUT.
- IDLE: sample_ready=1. On sample_valid, shift: window[0]<=sample_in, window[i]<=window[i-1], window[NUM_ELEM-1] dropped. Set f=0, k=0, go MAC. Before NUM_ELEM samples, unfilled taps are zero.
- MAC: sample_ready=0; coef_filt=f; coef_idx=k. Per cycle, prod = coef_data*window[k] (unsigned, full 2*BITS_PER_ELEM width).
  - k==0: acc<=prod. Otherwise acc<=acc+prod.
  - k==NUM_ELEM-1: go OUT.
  - Otherwise k<=k+1.
  - ACC_W never overflows.
- OUT: out_valid=1, out_data=acc, out_filt=f; all held stable until out_ready. On out_valid&&out_ready:
  - f==NUM_FILTERS-1: go IDLE, f<=0, out_valid<=0.
  - Otherwise f<=f+1, k<=0, go MAC, out_valid<=0.
- Timing: out_valid is first high NUM_ELEM+1 cycles after the sample handshake cycle. A full sweep with out_ready tied high is NUM_FILTERS*(NUM_ELEM+1) cycles, then 1 IDLE cycle before the next sample is taken.
- sample_valid outside IDLE is ignored; the sample is not consumed.
- out_ready while out_valid=0 has no effect.
- coef_filt/coef_idx outside MAC hold their last value; the table is don't-care then.

Optional Feature:
WAVELET_SCHED_DECIM_EN: adds a 1-bit phase register, reset 0, toggled on every accepted sample.
- Phase was 0: the sample shifts into the window, the block returns to IDLE next cycle, and no sweep runs.
- Phase was 1: the sample shifts and a normal sweep runs.
- Outputs are produced for every 2nd sample (decimate by 2).
- Without the macro: every accepted sample triggers a sweep; no phase register exists.

Test Plan:
- Reset/idle: assert rst_n=0 mid-MAC -> all outputs 0 immediately; after release, sample_ready=1, busy=0.
- Impulse: table model coef=f+1 for all k; after reset send sample 3, out_ready=1 -> outputs (filt,data) = (0,3),(1,6),(2,9),(3,12); first out_valid 8 cycles after the handshake.
- Window shift: then send 5 -> (0,8),(1,16),(2,24),(3,32). After 8 more samples of 0 the outputs are all 0 (the 3 and 5 have shifted out).
- Max range: 7 samples of 255, coef 255 -> out_data=455175 for every filter, no wrap.
- Back-pressure: hold out_ready=0 for 5 cycles in OUT -> out_data/out_filt stable, sample_valid ignored, sample_ready=0; release -> sweep continues with the next filter.
- DECIM (macro on): send 3 then 5 -> no outputs for 3; after 5, outputs (0,8),(1,16),(2,24),(3,32).
